pal_ingress_skid: RTL and testbench
===================================

# pal_ingress_skid

Two-entry elastic input stage directly upstream of the pipe_pal datapath. It accepts W_DATA-wide words with a frame-last marker over a valid/ready handshake and tags each word with its index within the frame. It presents the words downstream with registered valid and data and fully registered backpressure, and it counts completed frames. It decouples pipe_pal's stall timing from the producer at full throughput.

## Interface
- W_DATA, 32, payload width in bits
- W_CNT, 16, width of word-index and frame counters
- i_clk  in  1  sole clock; all logic on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  upstream word present
- o_ready  out  1  stage can accept a word; registered
- i_data  in  W_DATA  upstream payload
- i_last  in  1  word is last of its frame
- o_valid  out  1  downstream word present; registered
- i_ready  in  1  downstream accepts
- o_data  out  W_DATA  payload
- o_last  out  1  last marker travelling with o_data
- o_seq  out  W_CNT  index of o_data within its frame (0 = first word)
- o_frames  out  W_CNT  count of frames whose last word has left downstream
- o_occ  out  2  words held: 0, 1 or 2

## Operation
- Accept event: i_valid & o_ready. Send event: o_valid & i_ready.
- Two slots: main (drives o_*) and skid. Each slot holds data, last and seq.
- State machine, reset state EMPTY:
  - EMPTY (occ 0, o_valid 0, o_ready 1): accept → main, BUSY.
  - BUSY (occ 1, o_valid 1, o_ready 1):
    - accept & send → main reloads from input, stay BUSY.
    - accept only → skid loads, FULL.
    - send only → EMPTY.
  - FULL (occ 2, o_valid 1, o_ready 0): send → main loads skid, BUSY; otherwise hold.
- Input word-index counter:
  - Captured into the slot on each accept.
  - Increments on accept; cleared to 0 on an accept with i_last=1.
  - Wraps modulo 2^W_CNT with no flag.
- o_frames increments on a send with o_last=1 and saturates at 2^W_CNT-1.
- Word order is strictly preserved. No word is dropped or duplicated.
- i_data/i_last are don't-care when i_valid=0. o_data/o_last/o_seq hold their last value when o_valid=0.
- An upstream i_valid drop while o_ready=0 is tolerated. This is not a protocol violation at this stage.

## Timing
- Latency: a word accepted in cycle N is on o_* with o_valid=1 in cycle N+1, if the stage was EMPTY or a send occurred in cycle N.
- Throughput: one word per cycle sustained while i_ready=1.
- o_ready depends only on state registers. There is no combinational path from i_ready or i_valid to o_ready or o_valid.
- After one stall cycle o_ready is 0 from the next cycle. One extra word is absorbed by the skid.
- Reset, in the cycle i_rst is high and after:
  - State EMPTY, o_valid 0, o_ready 0, o_occ 0, o_data 0, o_last 0, o_seq 0, o_frames 0, word index 0.
  - o_ready rises in the first cycle after i_rst deasserts.
- Reset mid-operation discards both slots and the partial frame index in the same edge. Handshake inputs in a reset cycle are ignored.
- Simultaneous accept and send in FULL cannot occur because o_ready=0 there.

## Structure
- Shared package pal_pkg:
  - state enum (EMPTY, BUSY, FULL)
  - default W_DATA, W_CNT
  - slot struct {data, last, seq}
- One natural sub-module, pal_slot_reg: a loadable register for one slot, instantiated for main and skid.
- Target size 150–250 lines.

## Test plan
- Stream 8 words, last on word 3 and word 7, with i_ready held 1 → o_valid each cycle one cycle later; o_seq 0,1,2,3,0,1,2,3; o_frames reaches 2; o_ready never drops.
- i_ready=0 for 3 cycles during a continuous stream → o_occ goes 1→2; o_ready drops after exactly one extra accept; on release, data is in order with no loss and o_ready returns one cycle after the first send.
- i_ready toggles every cycle against i_valid random 50% across 1000 words → scoreboard sees exact order and correct seq; o_occ ≤ 2.
- Assert i_rst while FULL holding words A,B → next cycle o_valid=0, o_occ=0, o_frames=0; first post-reset word gets o_seq 0; A and B never appear.
- W_CNT=2 with a 6-word frame → o_seq 0,1,2,3,0,1; 4 one-word frames → o_frames saturates at 3.

Source files
------------

// File: rtl/pal_pkg.sv
// rtl/pal_pkg.sv - shared types and defaults for the pal ingress skid stage
package pal_pkg;

  localparam int W_DATA_DEF = 32;
  localparam int W_CNT_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [W_DATA_DEF-1:0] data;
    logic                  last;
    logic [W_CNT_DEF-1:0]  seq;
  } slot_t;

  function automatic logic [1:0] occ_of(input state_t s);
    case (s)
      BUSY:    return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pal_slot_reg.sv
// rtl/pal_slot_reg.sv - loadable register holding one {data, last, seq} slot
module pal_slot_reg #(
  parameter int W = 49
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] slot_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot_q <= '0;
    end else if (i_load) begin
      slot_q <= i_d;
    end
  end

  assign o_q = slot_q;

endmodule

// File: rtl/pal_ingress_skid.sv
// rtl/pal_ingress_skid.sv - two-entry elastic stage with word-in-frame tagging and frame count
module pal_ingress_skid
  import pal_pkg::*;
#(
  parameter int W_DATA = W_DATA_DEF,
  parameter int W_CNT  = W_CNT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [W_DATA-1:0] i_data,
  input  logic              i_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [W_DATA-1:0] o_data,
  output logic              o_last,
  output logic [W_CNT-1:0]  o_seq,
  output logic [W_CNT-1:0]  o_frames,
  output logic [1:0]        o_occ
);

  localparam int W_SLOT = W_DATA + 1 + W_CNT;

  state_t             state_q, state_d;
  logic               valid_q, ready_q;
  logic [1:0]         occ_q;
  logic [W_CNT-1:0]   idx_q, frames_q;
  logic               accept, send;
  logic               main_load, skid_load;
  logic [W_SLOT-1:0]  in_slot, main_d, main_q, skid_q;

  assign accept  = i_valid & ready_q;
  assign send    = valid_q & i_ready;
  assign in_slot = {i_data, i_last, idx_q};

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_slot;
    case (state_q)
      EMPTY: begin
        main_load = accept;
        if (accept) state_d = BUSY;
      end
      BUSY: begin
        main_load = accept & send;
        skid_load = accept & ~send;
        if (accept & ~send)      state_d = FULL;
        else if (~accept & send) state_d = EMPTY;
      end
      FULL: begin
        main_load = send;
        main_d    = skid_q;
        if (send) state_d = BUSY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // ready/valid/occ are registered from the next state so no input reaches them combinationally
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= EMPTY;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
      occ_q    <= 2'd0;
      idx_q    <= '0;
      frames_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
      ready_q <= (state_d != FULL);
      occ_q   <= occ_of(state_d);
      if (accept) begin
        idx_q <= i_last ? '0 : idx_q + 1'b1;
      end
      if (send && o_last && (frames_q != {W_CNT{1'b1}})) begin
        frames_q <= frames_q + 1'b1;
      end
    end
  end

  pal_slot_reg #(.W(W_SLOT)) u_main (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (main_load),
    .i_d    (main_d),
    .o_q    (main_q)
  );

  pal_slot_reg #(.W(W_SLOT)) u_skid (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (skid_load),
    .i_d    (in_slot),
    .o_q    (skid_q)
  );

  assign o_data   = main_q[W_SLOT-1 -: W_DATA];
  assign o_last   = main_q[W_CNT];
  assign o_seq    = main_q[W_CNT-1:0];
  assign o_valid  = valid_q;
  assign o_ready  = ready_q;
  assign o_occ    = occ_q;
  assign o_frames = frames_q;

endmodule

// File: tb/tb_pal_ingress_skid.sv
// tb/tb_pal_ingress_skid.sv - randomized and directed checks of pal_ingress_skid against a queue model
module tb_pal_ingress_skid;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [15:0] seq;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready_in = 1'b0;

  logic        a_ready, a_valid, a_last;
  logic [31:0] a_data;
  logic [15:0] a_seq, a_frames;
  logic [1:0]  a_occ;

  logic        b_ready, b_valid, b_last;
  logic [31:0] b_data;
  logic [1:0]  b_seq, b_frames;
  logic [1:0]  b_occ;

  int checks = 0;
  int errors = 0;

  word_t q[$];
  word_t hold;
  int    seq_m = 0;
  int    frames_m = 0;
  bit    ready_m = 1'b0;
  int    accepted = 0;

  always #5 clk = ~clk;

  pal_ingress_skid u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(a_ready),
    .i_data(in_data), .i_last(in_last), .o_valid(a_valid), .i_ready(out_ready_in),
    .o_data(a_data), .o_last(a_last), .o_seq(a_seq), .o_frames(a_frames), .o_occ(a_occ)
  );

  pal_ingress_skid #(.W_DATA(32), .W_CNT(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(b_ready),
    .i_data(in_data), .i_last(in_last), .o_valid(b_valid), .i_ready(out_ready_in),
    .o_data(b_data), .o_last(b_last), .o_seq(b_seq), .o_frames(b_frames), .o_occ(b_occ)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    word_t f;
    int    sz;
    sz = q.size();
    f  = (sz > 0) ? q[0] : hold;
    chk("valid",   64'(a_valid),  64'(sz > 0));
    chk("ready",   64'(a_ready),  64'(ready_m));
    chk("occ",     64'(a_occ),    64'(sz));
    chk("data",    64'(a_data),   64'(f.data));
    chk("last",    64'(a_last),   64'(f.last));
    chk("seq",     64'(a_seq),    64'(f.seq));
    chk("frames",  64'(a_frames), 64'(frames_m));
    chk("valid2",  64'(b_valid),  64'(sz > 0));
    chk("ready2",  64'(b_ready),  64'(ready_m));
    chk("occ2",    64'(b_occ),    64'(sz));
    chk("data2",   64'(b_data),   64'(f.data));
    chk("seq2",    64'(b_seq),    64'(f.seq % 4));
    chk("frames2", 64'(b_frames), 64'((frames_m > 3) ? 3 : frames_m));
  endtask

  // one clock: drive inputs, let the edge happen, advance the model, compare
  task automatic cyc(input logic v, input logic [31:0] d, input logic l, input logic r, input logic rs);
    bit acc, snd;
    rst = rs; in_valid = v; in_data = d; in_last = l; out_ready_in = r;
    acc = v && ready_m;
    snd = (q.size() > 0) && r;
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      seq_m = 0;
      frames_m = 0;
      hold = '{32'h0, 1'b0, 16'h0};
      ready_m = 1'b0;
    end else begin
      if (snd) begin
        if (q[0].last) frames_m++;
        void'(q.pop_front());
      end
      if (acc) begin
        q.push_back('{d, l, 16'(seq_m)});
        seq_m = l ? 0 : (seq_m + 1) % 65536;
        accepted++;
      end
      ready_m = (q.size() < 2);
      if (q.size() > 0) hold = q[0];
    end
    check_all();
  endtask

  initial begin
    int budget;
    bit tog;
    hold = '{32'h0, 1'b0, 16'h0};

    // reset and idle
    cyc(1'b1, 32'h1111_1111, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // 8-word stream, last on words 3 and 7, downstream always ready
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h100 + 32'(i), (i == 3) || (i == 7), 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("stream8_frames", 64'(a_frames), 64'd2);

    // continuous stream with a 3-cycle downstream stall
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b0, 1'b1, 1'b0);
    for (int i = 3; i < 6; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 1'b0);
    chk("stall_full", 64'(a_occ), 64'd2);
    for (int i = 6; i < 12; i++) cyc(1'b1, 32'h200 + 32'(i), i == 11, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // 1000 random words, i_ready toggling, i_valid 50%
    accepted = 0;
    budget = 0;
    tog = 1'b0;
    while (accepted < 1000 && budget < 8000) begin
      tog = ~tog;
      cyc(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0), tog, 1'b0);
      budget++;
    end
    chk("random_done", 64'(accepted >= 1000), 64'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // fill with A,B then reset while FULL; A and B must be discarded
    budget = 0;
    cyc(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0);
    while (q.size() < 2 && budget < 10) begin
      cyc(1'b1, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0);
      budget++;
    end
    chk("full_before_reset", 64'(a_occ), 64'd2);
    cyc(1'b1, 32'hCCCC_0003, 1'b0, 1'b1, 1'b1);
    chk("post_reset_valid", 64'(a_valid), 64'd0);
    chk("post_reset_occ", 64'(a_occ), 64'd0);
    chk("post_reset_frames", 64'(a_frames), 64'd0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
    chk("first_seq_after_reset", 64'(a_seq), 64'd0);
    cyc(1'b1, 32'h301, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // narrow-counter wrap and frame saturation
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 32'h400 + 32'(i), i == 5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h500 + 32'(i), 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("frames2_saturated", 64'(b_frames), 64'd3);
    chk("frames_wide", 64'(a_frames), 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
